// File: rtl/sar_seq_pkg.sv
// sar_seq_pkg
//   Shared types and helpers for the SAR scan sequencer slice.
//   - state_e  : scan FSM states
//   - ch_width : channel-number width for a given channel count

package sar_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    SAMPLE  = 3'd2,
    CONVERT = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  // Width of a channel number; never below one bit so ch_sel stays a real port.
  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// sar_result_fifo
//   First-word-fall-through FIFO for tagged SAR results. The head entry is
//   presented combinationally from the registered read pointer.
//   Ports:
//     clk, rstn        clock, async active-low reset
//     push, push_data  write request and data; accepted when not full, or
//                      when full and a pop happens in the same cycle
//     pop_req          pop request; ignored while empty
//     rd_valid         FIFO not empty
//     rd_data          head entry, zero while empty
//     full             FIFO holds DEPTH entries
//   DEPTH must be a power of two, at least 2.

module sar_result_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty;
  logic             pop;
  logic             wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = pop_req && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; empty pointers already mask stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sar_scan_sequencer.sv
// sar_scan_sequencer
//   Scans the enabled analog channels on a periodic timer or software trigger,
//   drives the mux select and S/H enable, runs each conversion through the SAR
//   start/done handshake and queues {channel, result} in a FWFT FIFO.
//   Ports:
//     clk, rstn          clock, async active-low reset
//     en                 sequencer enable
//     ch_mask            channels to scan, latched at scan start
//     sample_cycles      S/H acquisition length (0 acts as 1)
//     period             timer reload in cycles (0 disables the timer)
//     trig               single-cycle software scan request
//     ch_sel, sample     analog mux select and S/H enable
//     sar_start          one-cycle conversion start
//     sar_done, sar_data conversion-complete pulse and result
//     rd_valid, rd_data, rd_ready   FIFO read side
//     ovf, ovf_clr       sticky overflow flag and its clear
//     busy               FSM not idle
//     scan_done          one-cycle pulse at the end of each scan

module sar_scan_sequencer
  import sar_seq_pkg::*;
#(
  parameter  int SIZE  = 8,
  parameter  int NCH   = 4,
  parameter  int DEPTH = 4,
  localparam int CH_W  = ch_width(NCH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [NCH-1:0]       ch_mask,
  input  logic [3:0]           sample_cycles,
  input  logic [15:0]          period,
  input  logic                 trig,
  output logic [CH_W-1:0]      ch_sel,
  output logic                 sample,
  output logic                 sar_start,
  input  logic                 sar_done,
  input  logic [SIZE-1:0]      sar_data,
  output logic                 rd_valid,
  output logic [CH_W+SIZE-1:0] rd_data,
  input  logic                 rd_ready,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic                 busy,
  output logic                 scan_done
);

  state_e          state_q, state_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [CH_W:0]   idx_q, idx_d;       // one extra bit: idx may reach NCH
  logic [3:0]      cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic [15:0]     timer_q, timer_d;
  logic            tmr_load_q, tmr_load_d;
  logic [CH_W-1:0] ch_sel_q, ch_sel_d;
  logic            sample_q, sample_d;
  logic            sar_start_q, sar_start_d;
  logic            busy_q, busy_d;
  logic            scan_done_q, scan_done_d;
  logic            ovf_q, ovf_d;

  logic            found;
  logic [CH_W-1:0] found_ch;
  logic [3:0]      eff_cycles;
  logic            start_scan;
  logic            tmr_active;
  logic            fire;
  logic            push;
  logic            fifo_full;
  logic            drop;

  assign eff_cycles = (sample_cycles == 4'd0) ? 4'd1 : sample_cycles;
  assign start_scan = (state_q == IDLE) && en && (pending_q || trig);
  assign push       = (state_q == CONVERT) && sar_done;
  assign drop       = push && fifo_full && !(rd_ready && rd_valid);

  // Lowest masked channel at or above idx; descending loop so the last hit wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    found    = 1'b0;
    found_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(idx_q))) begin
        found    = 1'b1;
        found_ch = CH_W'(i);
      end
    end
  end

  // Timer reloads on the first active cycle after being idle, then fires every
  // `period` cycles.
  always_comb begin
    tmr_active = en && (period != 16'd0);
    fire       = tmr_active && !tmr_load_q && (timer_q == 16'd0);
    timer_d    = timer_q;
    tmr_load_d = tmr_load_q;
    if (!tmr_active) begin
      tmr_load_d = 1'b1;
    end else if (tmr_load_q || fire) begin
      timer_d    = period - 16'd1;
      tmr_load_d = 1'b0;
    end else begin
      timer_d = timer_q - 16'd1;
    end
  end

  // Single pending bit: extra requests during a scan coalesce into one follow-on scan.
  always_comb begin
    pending_d = pending_q;
    if (!en) begin
      pending_d = 1'b0;
    end else begin
      if (start_scan) pending_d = 1'b0;
      if (fire || (trig && !start_scan)) pending_d = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      timer_q     <= '0;
      tmr_load_q  <= 1'b1;
      ch_sel_q    <= '0;
      sample_q    <= 1'b0;
      sar_start_q <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
      tmr_load_q  <= tmr_load_d;
      ch_sel_q    <= ch_sel_d;
      sample_q    <= sample_d;
      sar_start_q <= sar_start_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
      ovf_q       <= ovf_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_scan) begin
          mask_d  = ch_mask;
          idx_d   = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (found) begin
          cnt_d   = eff_cycles;
          state_d = SAMPLE;
        end else begin
          state_d = IDLE;
        end
      end
      SAMPLE: begin
        if (!en) begin
          state_d = IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = CONVERT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CONVERT: begin
        // A result arriving as en drops is still kept; nothing is left to drain.
        if (sar_done) begin
          idx_d   = {1'b0, ch_sel_q} + (CH_W+1)'(1);
          state_d = en ? SELECT : IDLE;
        end else if (!en) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (sar_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: registered outputs, computed from the transition being taken
  always_comb begin
    ch_sel_d    = ch_sel_q;
    if ((state_q == SELECT) && en && found) ch_sel_d = found_ch;
    sample_d    = (state_d == SAMPLE);
    sar_start_d = (state_q == SAMPLE) && (state_d == CONVERT);
    busy_d      = (state_d != IDLE);
    scan_done_d = (state_q == SELECT) && en && !found;
    // A new overflow outranks a clear in the same cycle.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  sar_result_fifo #(
    .WIDTH (CH_W + SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data ({ch_sel_q, sar_data}),
    .pop_req   (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .full      (fifo_full)
  );

  assign ch_sel    = ch_sel_q;
  assign sample    = sample_q;
  assign sar_start = sar_start_q;
  assign busy      = busy_q;
  assign scan_done = scan_done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
// tb_sar_scan_sequencer
//   Directed bench for sar_scan_sequencer with NCH=4, SIZE=8, DEPTH=4 and a
//   SAR model with a fixed 10-cycle latency. Inputs are driven and outputs
//   sampled on the falling edge; N<k> below is the k-th falling edge after a
//   trig pulse was driven.

module tb_sar_scan_sequencer;

  localparam int SIZE    = 8;
  localparam int NCH     = 4;
  localparam int DEPTH   = 4;
  localparam int CH_W    = 2;
  localparam int SAR_LAT = 10;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 en;
  logic [NCH-1:0]       ch_mask;
  logic [3:0]           sample_cycles;
  logic [15:0]          period;
  logic                 trig;
  logic [CH_W-1:0]      ch_sel;
  logic                 sample;
  logic                 sar_start;
  logic                 sar_done;
  logic [SIZE-1:0]      sar_data;
  logic                 rd_valid;
  logic [CH_W+SIZE-1:0] rd_data;
  logic                 rd_ready;
  logic                 ovf;
  logic                 ovf_clr;
  logic                 busy;
  logic                 scan_done;

  always #5 clk = ~clk;

  sar_scan_sequencer #(
    .SIZE  (SIZE),
    .NCH   (NCH),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .ch_mask       (ch_mask),
    .sample_cycles (sample_cycles),
    .period        (period),
    .trig          (trig),
    .ch_sel        (ch_sel),
    .sample        (sample),
    .sar_start     (sar_start),
    .sar_done      (sar_done),
    .sar_data      (sar_data),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_ready      (rd_ready),
    .ovf           (ovf),
    .ovf_clr       (ovf_clr),
    .busy          (busy),
    .scan_done     (scan_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SAR model: sar_done exactly SAR_LAT cycles after sar_start, data from sar_q.
  logic [7:0] sar_q[$];
  int         sar_cnt = 0;
  initial begin
    sar_done = 1'b0;
    sar_data = '0;
    forever begin
      @(negedge clk);
      sar_done = 1'b0;
      if (sar_cnt > 0) begin
        sar_cnt--;
        if (sar_cnt == 0) begin
          sar_done = 1'b1;
          if (sar_q.size() > 0) sar_data = sar_q.pop_front();
          else                  sar_data = 8'h5A;
        end
      end
      if (sar_start === 1'b1) sar_cnt = SAR_LAT;
    end
  end

  // Event counters, sampled once all inputs of the cycle are settled.
  int n_sample = 0;
  int n_start  = 0;
  int n_done   = 0;
  int mon_cyc  = 0;
  int pop_cyc[$];
  initial begin
    forever begin
      @(negedge clk);
      #1;
      mon_cyc++;
      if (sample === 1'b1)    n_sample++;
      if (sar_start === 1'b1) n_start++;
      if (scan_done === 1'b1) n_done++;
      if (rd_valid === 1'b1 && rd_ready === 1'b1) pop_cyc.push_back(mon_cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at N1.
  task automatic pulse_trig();
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (scan_done !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, scan_done, 1);
  endtask

  int s0, st0, d0, p0;

  initial begin
    rstn = 1'b0; en = 1'b0; trig = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    ch_mask = '0; sample_cycles = 4'd3; period = 16'd0;
    tick(2);
    check("rst_ch_sel",    ch_sel, 0);
    check("rst_sample",    sample, 0);
    check("rst_sar_start", sar_start, 0);
    check("rst_busy",      busy, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_rd_valid",  rd_valid, 0);
    check("rst_rd_data",   rd_data, 0);
    check("rst_ovf",       ovf, 0);
    rstn = 1'b1;
    en   = 1'b1;
    tick(2);

    // Two-channel scan, mask 1010, 3 sample cycles.
    ch_mask = 4'b1010;
    sar_q.push_back(8'hA5);
    sar_q.push_back(8'h3C);
    s0 = n_sample; st0 = n_start; d0 = n_done;
    pulse_trig();                                  // N1: SELECT
    check("t1_busy_n1",   busy, 1);
    check("t1_sample_n1", sample, 0);
    tick(1);                                       // N2
    check("t1_sample_n2", sample, 1);
    check("t1_ch_sel_n2", ch_sel, 1);
    tick(2);                                       // N4
    check("t1_sample_n4", sample, 1);
    check("t1_start_n4",  sar_start, 0);
    tick(1);                                       // N5
    check("t1_sample_n5", sample, 0);
    check("t1_start_n5",  sar_start, 1);
    tick(1);                                       // N6
    check("t1_start_n6",  sar_start, 0);
    tick(10);                                      // N16
    check("t1_rd_valid",  rd_valid, 1);
    check("t1_head0",     rd_data, 10'h1A5);
    tick(16);                                      // N32
    check("t1_scan_done", scan_done, 1);
    check("t1_busy_end",  busy, 0);
    check("t1_head0_end", rd_data, 10'h1A5);
    rd_ready = 1'b1;
    tick(1);
    check("t1_head1",     rd_data, 10'h33C);
    check("t1_samples",   n_sample - s0, 6);
    check("t1_starts",    n_start - st0, 2);
    check("t1_dones",     n_done - d0, 1);
    tick(1);
    rd_ready = 1'b0;
    check("t1_empty",     rd_valid, 0);

    // Empty mask: scan_done two cycles after trig, nothing converted.
    ch_mask = 4'b0000;
    st0 = n_start;
    pulse_trig();
    check("t2_done_n1", scan_done, 0);
    check("t2_busy_n1", busy, 1);
    tick(1);
    check("t2_done_n2", scan_done, 1);
    check("t2_busy_n2", busy, 0);
    tick(1);
    check("t2_done_n3", scan_done, 0);
    check("t2_starts",  n_start - st0, 0);
    check("t2_empty",   rd_valid, 0);

    // sample_cycles = 0 behaves as one cycle.
    ch_mask = 4'b0001;
    sample_cycles = 4'd0;
    sar_q.push_back(8'h77);
    pulse_trig();
    tick(1);                                       // N2
    check("t3_sample_n2", sample, 1);
    check("t3_ch_sel",    ch_sel, 0);
    tick(1);                                       // N3
    check("t3_sample_n3", sample, 0);
    check("t3_start_n3",  sar_start, 1);
    tick(11);                                      // N14
    check("t3_head",      rd_data, 10'h077);
    wait_done("t3_scan_done", 10);
    sample_cycles = 4'd3;
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check("t3_empty", rd_valid, 0);

    // Two extra triggers during a scan give exactly one follow-on scan.
    rd_ready = 1'b1;
    st0 = n_start; d0 = n_done; p0 = pop_cyc.size();
    pulse_trig();
    tick(2);
    trig = 1'b1; tick(1); trig = 1'b0;
    tick(2);
    trig = 1'b1; tick(1); trig = 1'b0;
    tick(80);
    check("t4_dones",  n_done - d0, 2);
    check("t4_starts", n_start - st0, 2);
    check("t4_pops",   pop_cyc.size() - p0, 2);
    rd_ready = 1'b0;

    // Overflow: 4 stored, 5th dropped, clear, then push-with-pop when full.
    sar_q.push_back(8'h11); sar_q.push_back(8'h22); sar_q.push_back(8'h33);
    sar_q.push_back(8'h44); sar_q.push_back(8'h55); sar_q.push_back(8'h66);
    ch_mask = 4'b1111;
    pulse_trig();
    wait_done("t5_scan4", 200);
    check("t5_ovf_full",  ovf, 0);
    check("t5_head_full", rd_data, 10'h011);
    ch_mask = 4'b0001;
    tick(1);
    pulse_trig();
    wait_done("t5_scan5", 60);
    check("t5_ovf_set",   ovf, 1);
    check("t5_head_kept", rd_data, 10'h011);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t5_ovf_clr",   ovf, 0);
    pulse_trig();                                  // N1
    tick(14);                                      // N15: sar_done high
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check("t5_ovf_pushpop", ovf, 0);
    check("t5_head_a", rd_data, 10'h122);
    wait_done("t5_scan6", 10);
    rd_ready = 1'b1;
    check("t5_pop_a", rd_data, 10'h122);
    tick(1);
    check("t5_pop_b", rd_data, 10'h233);
    tick(1);
    check("t5_pop_c", rd_data, 10'h344);
    tick(1);
    check("t5_pop_d", rd_data, 10'h066);
    tick(1);
    rd_ready = 1'b0;
    check("t5_drained", rd_valid, 0);

    // en dropped in CONVERT: drain the result, no push.
    st0 = n_start;
    pulse_trig();
    tick(6);                                       // N7: CONVERT
    en = 1'b0;
    tick(1);                                       // N8: DRAIN
    check("t6_busy_drain",  busy, 1);
    check("t6_sample_drain", sample, 0);
    tick(7);                                       // N15: sar_done
    check("t6_busy_n15",    busy, 1);
    tick(1);                                       // N16
    check("t6_idle",        busy, 0);
    check("t6_no_push",     rd_valid, 0);
    check("t6_starts",      n_start - st0, 1);
    en = 1'b1;

    // en dropped in SAMPLE: sample falls next cycle, no conversion.
    st0 = n_start;
    pulse_trig();
    tick(1);                                       // N2
    check("t7_sample_on", sample, 1);
    en = 1'b0;
    tick(1);
    check("t7_sample_off", sample, 0);
    check("t7_idle",       busy, 0);
    en = 1'b1;
    tick(20);
    check("t7_starts", n_start - st0, 0);

    // Periodic timer: one push every 100 cycles.
    rd_ready = 1'b1;
    p0 = pop_cyc.size();
    period = 16'd100;
    begin
      int k = 0;
      while (pop_cyc.size() < p0 + 3 && k < 500) begin
        tick(1);
        k++;
      end
    end
    check("t8_pops", pop_cyc.size() - p0, 3);
    if (pop_cyc.size() >= p0 + 3) begin
      check("t8_gap1", pop_cyc[p0+1] - pop_cyc[p0], 100);
      check("t8_gap2", pop_cyc[p0+2] - pop_cyc[p0+1], 100);
    end
    period = 16'd0;
    tick(40);
    check("t8_idle", busy, 0);
    rd_ready = 1'b0;

    // Reset asserted mid-SAMPLE with a result queued.
    ch_mask = 4'b0010;
    pulse_trig();
    wait_done("t9_prefill", 60);
    check("t9_queued", rd_valid, 1);
    pulse_trig();
    tick(1);                                       // N2
    check("t9_sample_pre", sample, 1);
    check("t9_ch_sel_pre", ch_sel, 1);
    rstn = 1'b0;
    #1;
    check("t9_sample",   sample, 0);
    check("t9_busy",     busy, 0);
    check("t9_ch_sel",   ch_sel, 0);
    check("t9_rd_valid", rd_valid, 0);
    check("t9_rd_data",  rd_data, 0);
    check("t9_ovf",      ovf, 0);
    tick(2);
    rstn = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
